s27_scan_tester: RTL and testbench

- Sequential test-access controller for the s27 combinational core. It is the driving and observing end of that core's interface.
- Accepts test patterns (primary inputs G0..G3 plus present state G5..G7) over a valid/ready handshake.
- Loads the present state through a 3-flop scan chain, applies the pattern and captures one clock of core response (next state G10/G11/G13 plus output G17).
- Scans the response out and returns it over a second valid/ready handshake.
- Sits between the pattern source (ATPG playback or fault-sim bench) and an externally instantiated s27 core.

---
 rtl/s27_scan_tester.sv | 146 ++++++++++++++
 tb/tb_s27_scan_tester.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s27_scan_tester.sv
`default_nettype none
// ============================================================================
// Module   : s27_scan_tester
// Function : Test-access controller for the s27 core. It accepts a pattern,
//            scan-loads the present state, captures one clock of core
//            response, scans it back out and returns it over a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module s27_scan_tester #(
    parameter int CHAIN_LEN = 3,   // s27 flop count; other values unsupported
    parameter int CNT_W     = 16
) (
    input  logic             CK,
    input  logic             RST,
    // pattern side
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [3:0]       pat_pi,
    input  logic [2:0]       pat_state,
    // core side
    output logic [3:0]       core_pi,
    output logic [2:0]       core_ps,
    input  logic             core_g10,
    input  logic             core_g11,
    input  logic             core_g13,
    input  logic             core_g17,
    output logic             scan_en,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_state,
    output logic             rsp_po,
    output logic [CNT_W-1:0] pat_cnt
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SHIFT_IN  = 3'd1;
    localparam logic [2:0] c_CAPTURE   = 3'd2;
    localparam logic [2:0] c_SHIFT_OUT = 3'd3;
    localparam logic [2:0] c_RESP      = 3'd4;

    localparam logic [1:0] c_LAST = 2'(CHAIN_LEN - 1);

    logic [2:0]           r_state;
    logic [1:0]           r_shift_cnt;
    logic [3:0]           r_core_pi;
    // r_chain[0] is G5, r_chain[1] is G6, r_chain[2] is G7 (scan out)
    logic [CHAIN_LEN-1:0] r_chain;
    // shift source: MSB is the next bit to enter the chain
    logic [CHAIN_LEN-1:0] r_src;
    logic [CHAIN_LEN-1:0] r_rsp;
    logic                 r_rsp_po;
    logic                 r_rsp_valid;
    logic [CNT_W-1:0]     r_pat_cnt;

    logic                 w_scan_in;
    logic                 w_accept;
    logic                 w_shifting;

    assign w_accept   = (r_state == c_IDLE) && pat_valid;
    assign w_shifting = (r_state == c_SHIFT_IN) || (r_state == c_SHIFT_OUT);
    // Zeros are shifted in while unloading so the chain ends clean.
    assign w_scan_in  = (r_state == c_SHIFT_IN) ? r_src[CHAIN_LEN-1] : 1'b0;

    assign pat_ready = (r_state == c_IDLE);
    assign scan_en   = w_shifting;
    assign core_pi   = r_core_pi;
    assign core_ps   = r_chain;
    assign rsp_valid = r_rsp_valid;
    assign rsp_state = r_rsp;
    assign rsp_po    = r_rsp_po;
    assign pat_cnt   = r_pat_cnt;

    // Sequencer: handshake, shift counting and completion counting.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_shift_cnt <= 2'd0;
            r_core_pi   <= 4'd0;
            r_src       <= '0;
            r_rsp_valid <= 1'b0;
            r_pat_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_core_pi   <= pat_pi;
                        r_src       <= pat_state;
                        r_shift_cnt <= 2'd0;
                        r_state     <= c_SHIFT_IN;
                    end
                end
                c_SHIFT_IN: begin
                    r_src       <= {r_src[CHAIN_LEN-2:0], 1'b0};
                    r_shift_cnt <= r_shift_cnt + 2'd1;
                    if (r_shift_cnt == c_LAST) begin
                        r_state <= c_CAPTURE;
                    end
                end
                c_CAPTURE: begin
                    r_shift_cnt <= 2'd0;
                    r_state     <= c_SHIFT_OUT;
                end
                c_SHIFT_OUT: begin
                    r_shift_cnt <= r_shift_cnt + 2'd1;
                    if (r_shift_cnt == c_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_pat_cnt   <= r_pat_cnt + 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Scan chain, functional capture and response assembly.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_chain  <= '0;
            r_rsp    <= '0;
            r_rsp_po <= 1'b0;
        end else begin
            if (w_shifting) begin
                r_chain <= {r_chain[CHAIN_LEN-2:0], w_scan_in};
            end else if (r_state == c_CAPTURE) begin
                r_chain  <= {core_g13, core_g11, core_g10};
                r_rsp_po <= core_g17;
            end
            // Scan-out bits arrive G13 first, so they land MSB-first.
            if (r_state == c_SHIFT_OUT) begin
                r_rsp <= {r_rsp[CHAIN_LEN-2:0], r_chain[CHAIN_LEN-1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s27_scan_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_s27_scan_tester
// Function : Self-checking bench for s27_scan_tester with a golden s27 core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s27_scan_tester;

    logic        CK = 1'b0;
    logic        RST;
    logic        pat_valid;
    logic [3:0]  pat_pi;
    logic [2:0]  pat_state;
    logic        rsp_ready;

    logic        pat_ready,  pat_ready2;
    logic [3:0]  core_pi,    core_pi2;
    logic [2:0]  core_ps,    core_ps2;
    logic        scan_en,    scan_en2;
    logic        rsp_valid,  rsp_valid2;
    logic [2:0]  rsp_state,  rsp_state2;
    logic        rsp_po,     rsp_po2;
    logic [15:0] pat_cnt;
    logic [1:0]  pat_cnt2;
    logic        g10, g11, g13, g17;
    logic        h10, h11, h13, h17;

    int tests  = 0;
    int failed = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [2:0] st;
        logic       po;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] pi;
        logic [2:0] st;
        logic [2:0] exp_st;
        logic       exp_po;
        int         hold;
    } vec_t;
    vec_t vecs[8];

    always #5 CK = ~CK;

    // Golden s27 combinational core; returns {G17,G13,G11,G10}.
    function automatic logic [3:0] s27(input logic [3:0] pi, input logic [2:0] ps);
        logic g0, g1, g2, g3, g5, g6, g7;
        logic x8, x9, x10, x11, x12, x13, x14, x15, x16, x17;
        {g3, g2, g1, g0} = pi;
        {g7, g6, g5}     = ps;
        x14 = ~g0;
        x12 = ~(g1 | g7);
        x8  = x14 & g6;
        x15 = x12 | x8;
        x16 = g3 | x8;
        x9  = ~(x16 & x15);
        x11 = ~(g5 | x9);
        x10 = ~(x14 | x11);
        x13 = ~(g2 | x12);
        x17 = ~x11;
        return {x17, x13, x11, x10};
    endfunction

    assign {g17, g13, g11, g10} = s27(core_pi, core_ps);
    assign {h17, h13, h11, h10} = s27(core_pi2, core_ps2);

    s27_scan_tester #(.CHAIN_LEN(3), .CNT_W(16)) dut (
        .CK(CK), .RST(RST),
        .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_pi(pat_pi), .pat_state(pat_state),
        .core_pi(core_pi), .core_ps(core_ps),
        .core_g10(g10), .core_g11(g11), .core_g13(g13), .core_g17(g17),
        .scan_en(scan_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_state(rsp_state), .rsp_po(rsp_po),
        .pat_cnt(pat_cnt)
    );

    // Narrow-counter twin, used to exercise counter wrap in a few patterns.
    s27_scan_tester #(.CHAIN_LEN(3), .CNT_W(2)) dut2 (
        .CK(CK), .RST(RST),
        .pat_valid(pat_valid), .pat_ready(pat_ready2),
        .pat_pi(pat_pi), .pat_state(pat_state),
        .core_pi(core_pi2), .core_ps(core_ps2),
        .core_g10(h10), .core_g11(h11), .core_g13(h13), .core_g17(h17),
        .scan_en(scan_en2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_state(rsp_state2), .rsp_po(rsp_po2),
        .pat_cnt(pat_cnt2)
    );

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_counts();
        chk("pat_cnt", {16'd0, pat_cnt}, exp_cnt & 32'hFFFF);
        chk("pat_cnt_narrow", {30'd0, pat_cnt2}, exp_cnt & 32'h3);
    endtask

    task automatic apply_reset(input int cycles);
        RST = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            pat_valid = 1'($urandom);
            pat_pi    = 4'($urandom);
            pat_state = 3'($urandom);
            rsp_ready = 1'($urandom);
            tick();
        end
        RST       = 1'b0;
        pat_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_cnt   = 0;
    endtask

    // Drive one pattern through the full sequence; hold = back-pressure cycles.
    task automatic do_pattern(input logic [3:0] pi, input logic [2:0] st,
                              input logic [2:0] es, input logic epo, input int hold);
        exp_t e;
        bit   got;
        logic [2:0] s_held;
        logic       po_held;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (pat_ready) got = 1'b1;
            else tick();
        end
        if (!got) chk("pat_ready_wait", 0, 1);
        pat_valid = 1'b1;
        pat_pi    = pi;
        pat_state = st;
        rsp_ready = (hold == 0);
        e.st = es;
        e.po = epo;
        sb.push_back(e);
        tick();                         // cycle 0 edge: acceptance
        pat_valid = 1'b0;
        pat_pi    = 4'($urandom);
        pat_state = 3'($urandom);
        for (int k = 1; k <= 7; k++) begin
            chk("scan_en", {31'd0, scan_en}, (k <= 3 || k >= 5) ? 1 : 0);
            chk("pat_ready_busy", {31'd0, pat_ready}, 0);
            chk("rsp_valid_early", {31'd0, rsp_valid}, 0);
            if (k == 4) begin
                chk("core_ps_loaded", {29'd0, core_ps}, {29'd0, st});
                chk("core_pi_applied", {28'd0, core_pi}, {28'd0, pi});
            end
            tick();
        end
        // cycle 8: response must be up now
        chk("rsp_valid_cycle8", {31'd0, rsp_valid}, 1);
        got = rsp_valid;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = rsp_valid;
        end
        if (!got) begin
            chk("rsp_valid_timeout", 0, 1);
            void'(sb.pop_front());
            rsp_ready = 1'b0;
            return;
        end
        e = sb.pop_front();
        chk("rsp_state", {29'd0, rsp_state}, {29'd0, e.st});
        chk("rsp_po", {31'd0, rsp_po}, {31'd0, e.po});
        chk("chain_cleared", {29'd0, core_ps}, 0);
        s_held  = rsp_state;
        po_held = rsp_po;
        for (int i = 0; i < hold; i++) begin
            pat_valid = 1'b1;           // must be ignored outside IDLE
            pat_pi    = ~pi;
            pat_state = ~st;
            tick();
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 1);
            chk("bp_rsp_state", {29'd0, rsp_state}, {29'd0, s_held});
            chk("bp_rsp_po", {31'd0, rsp_po}, {31'd0, po_held});
            chk("bp_pat_ready", {31'd0, pat_ready}, 0);
            chk("bp_core_pi", {28'd0, core_pi}, {28'd0, pi});
        end
        pat_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 0);
        chk("pat_ready_back", {31'd0, pat_ready}, 1);
        chk("core_pi_held", {28'd0, core_pi}, {28'd0, pi});
        check_counts();
    endtask

    initial begin
        logic [3:0] r;
        RST       = 1'b1;
        pat_valid = 1'b0;
        pat_pi    = 4'd0;
        pat_state = 3'd0;
        rsp_ready = 1'b0;

        // Reset state with random inputs during reset
        apply_reset(2);
        chk("rst_pat_ready", {31'd0, pat_ready}, 1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_core_ps", {29'd0, core_ps}, 0);
        chk("rst_core_pi", {28'd0, core_pi}, 0);
        chk("rst_scan_en", {31'd0, scan_en}, 0);
        chk("rst_rsp_state", {29'd0, rsp_state}, 0);
        chk("rst_rsp_po", {31'd0, rsp_po}, 0);
        check_counts();

        // Vector table: hand-derived entries first, then model-derived ones
        vecs[0] = '{4'b0000, 3'b000, 3'b000, 1'b1, 0};
        vecs[1] = '{4'b0001, 3'b000, 3'b001, 1'b1, 0};
        vecs[2] = '{4'b1001, 3'b000, 3'b010, 1'b0, 0};
        vecs[3] = '{4'b0110, 3'b101, 3'b000, 1'b0, 5};  // scan-load + back-pressure
        for (int i = 4; i < 8; i++) begin
            vecs[i].pi   = 4'($urandom);
            vecs[i].st   = 3'($urandom);
            r            = s27(vecs[i].pi, vecs[i].st);
            vecs[i].exp_st = r[2:0];
            vecs[i].exp_po = r[3];
            vecs[i].hold = (i == 6) ? 2 : 0;
        end
        r = s27(4'b0110, 3'b101);
        vecs[3].exp_st = r[2:0];
        vecs[3].exp_po = r[3];

        for (int i = 0; i < 8; i++) begin
            do_pattern(vecs[i].pi, vecs[i].st, vecs[i].exp_st, vecs[i].exp_po, vecs[i].hold);
        end

        // Reset in the middle of SHIFT_OUT (during cycle 6)
        begin
            bit seen;
            while (!pat_ready) tick();
            pat_valid = 1'b1;
            pat_pi    = 4'b1111;
            pat_state = 3'b111;
            rsp_ready = 1'b1;
            tick();
            pat_valid = 1'b0;
            for (int k = 1; k <= 5; k++) tick();
            RST = 1'b1;
            tick();
            RST = 1'b0;
            exp_cnt = 0;
            chk("midrst_pat_ready", {31'd0, pat_ready}, 1);
            chk("midrst_core_ps", {29'd0, core_ps}, 0);
            chk("midrst_scan_en", {31'd0, scan_en}, 0);
            chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
            check_counts();
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (rsp_valid) seen = 1'b1;
            end
            chk("midrst_no_rsp", {31'd0, seen}, 0);
            rsp_ready = 1'b0;
        end

        // Four completions wrap the narrow counter back to zero
        for (int i = 0; i < 4; i++) begin
            logic [3:0] pi;
            logic [2:0] st;
            pi = 4'($urandom);
            st = 3'($urandom);
            r  = s27(pi, st);
            do_pattern(pi, st, r[2:0], r[3], 0);
        end
        chk("narrow_wrap", {30'd0, pat_cnt2}, 0);
        chk("wide_after_wrap", {16'd0, pat_cnt}, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
